// File: rtl/mult_ct_radix.sv
// mult_ct_radix: radix-2^DIGIT shift-add unsigned multiplier.
// Consumes DIGIT multiplier bits per cycle, so a product takes WIDTH/DIGIT
// cycles for every operand pair. busy is high while the product is being
// accumulated. finish pulses for one cycle at completion. out holds the
// product until the next accepted start.
// Optional build macro: EARLY_TERM_EN. When it is defined, CALC exits as soon
// as the remaining multiplier bits are zero, which makes the latency depend on
// the data. Use it only for side-channel comparison, never in secure builds.
module mult_ct_radix #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   out,
    output logic                 finish
);

    localparam int N   = WIDTH / DIGIT;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int PPW = WIDTH + DIGIT;
    localparam int OW  = 2 * WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CW-1:0]     cnt_r;
    logic [WIDTH-1:0]  in1_r;
    logic [WIDTH-1:0]  in2_r;
    logic [OW-1:0]     acc_r;
    logic              finish_r;

    logic [PPW-1:0]    pp_s;
    logic [OW-1:0]     pp_ext_s;
    logic [OW-1:0]     acc_nxt_s;
    logic [WIDTH-1:0]  in1_shift_s;
    logic [31:0]       shamt_s;
    logic              accept_s;
    logic              last_s;

    // Partial product and accumulation, evaluated every CALC cycle regardless of digit value
    always_comb begin
        pp_s        = PPW'(in2_r) * PPW'(in1_r[DIGIT-1:0]);
        shamt_s     = 32'(cnt_r) * 32'(DIGIT);
        pp_ext_s    = OW'(pp_s) << shamt_s;
        acc_nxt_s   = acc_r + pp_ext_s;
        in1_shift_s = in1_r >> DIGIT;
    end

    // Accept and last-cycle detection
    always_comb begin
        accept_s = (state_r == IDLE) && start;
`ifdef EARLY_TERM_EN
        last_s   = (cnt_r == CW'(N - 1)) || (in1_shift_s == {WIDTH{1'b0}});
`else
        last_s   = (cnt_r == CW'(N - 1));
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: IDLE -> CALC on start, CALC -> IDLE on the last digit
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Datapath registers: operand capture, accumulate/shift/count, completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in1_r    <= {WIDTH{1'b0}};
            in2_r    <= {WIDTH{1'b0}};
            acc_r    <= {OW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            finish_r <= 1'b0;
        end else if (accept_s) begin
            in1_r    <= in1;
            in2_r    <= in2;
            acc_r    <= {OW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            finish_r <= 1'b0;
        end else if (state_r == CALC) begin
            acc_r    <= acc_nxt_s;
            in1_r    <= in1_shift_s;
            cnt_r    <= last_s ? {CW{1'b0}} : (cnt_r + CW'(1));
            finish_r <= last_s;
        end else begin
            finish_r <= 1'b0;
        end
    end

    // Output decode straight from registers
    always_comb begin
        if (state_r == CALC) begin
            busy = 1'b1;
        end else begin
            busy = 1'b0;
        end
        out    = acc_r;
        finish = finish_r;
    end

endmodule

// File: tb/tb_mult_ct_radix.sv
// Testbench for mult_ct_radix. It builds a W8/D1 instance and a W16/D4 instance.
// Expected products come from plain multiplication. Expected latency comes
// from the digit rule. The bench covers table vectors, random operands and
// the protocol corner cases.
module tb_mult_ct_radix;

    logic        clk;
    logic        rst_n;

    logic        s8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic [15:0] out8;
    logic        fin8;

    logic        s16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        busy16;
    logic [31:0] out16;
    logic        fin16;

    int n_cmp;
    int n_bad;

    mult_ct_radix #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .in1(a8), .in2(b8),
        .busy(busy8), .out(out8), .finish(fin8)
    );

    mult_ct_radix #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(s16), .in1(a16), .in2(b16),
        .busy(busy16), .out(out16), .finish(fin16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Latency from the digit rule: N cycles. With early termination it is
    // max(1, highest nonzero digit index + 1).
    function automatic int lat_model(input longint unsigned a, input int width, input int digit);
        int h;
        int early;
        h = -1;
        for (int i = 0; i < width / digit; i++) begin
            if (((a >> (i * digit)) & ((64'd1 << digit) - 64'd1)) != 64'd0) h = i;
        end
        early = (h + 1 < 1) ? 1 : h + 1;
`ifdef EARLY_TERM_EN
        return early;
`else
        return width / digit;
`endif
    endfunction

    function automatic logic cur_fin(input bit w16);
        return w16 ? fin16 : fin8;
    endfunction

    function automatic logic cur_busy(input bit w16);
        return w16 ? busy16 : busy8;
    endfunction

    function automatic longint cur_out(input bit w16);
        return w16 ? longint'(out16) : longint'(out8);
    endfunction

    // One complete operation: accept, count cycles to finish, check result and hold
    task automatic do_op(input bit w16, input logic [15:0] a, input logic [15:0] b,
                         input longint exp_out, input string tag);
        int cyc;
        int exp_lat;
        bit busy_ok;
        exp_lat = lat_model(longint'(a), w16 ? 16 : 8, w16 ? 4 : 1);
        @(negedge clk);
        if (w16) begin
            s16 = 1'b1; a16 = a; b16 = b;
        end else begin
            s8 = 1'b1; a8 = a[7:0]; b8 = b[7:0];
        end
        @(posedge clk);
        #1;
        s8 = 1'b0;
        s16 = 1'b0;
        cyc = 0;
        busy_ok = 1'b1;
        while (!cur_fin(w16) && cyc < 64) begin
            if (!cur_busy(w16)) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_out"}, cur_out(w16), exp_out);
        check({tag, "_busy_during"}, busy_ok, 1);
        check({tag, "_busy_at_finish"}, cur_busy(w16), 0);
        @(posedge clk);
        #1;
        check({tag, "_finish_one_cycle"}, cur_fin(w16), 0);
        check({tag, "_out_held"}, cur_out(w16), exp_out);
    endtask

    initial begin
        vec_t tab[8];
        int cyc;
        bit ok;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [15:0] wa;
        logic [15:0] wb;

        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        s8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        s16 = 1'b0; a16 = 16'd0; b16 = 16'd0;

        tab[0] = '{16'd200,  16'd255, 32'd51000};
        tab[1] = '{16'd0,    16'd255, 32'd0};
        tab[2] = '{16'd1,    16'd255, 32'd255};
        tab[3] = '{16'd255,  16'd255, 32'd65025};
        tab[4] = '{16'd1,    16'd9,   32'd9};
        tab[5] = '{16'h80,   16'd9,   32'h480};
        tab[6] = '{16'd255,  16'd0,   32'd0};
        tab[7] = '{16'd37,   16'd113, 32'd4181};

        // reset state, then idle after release
        #12;
        check("reset_busy", busy8, 0);
        check("reset_out", out8, 0);
        check("reset_finish", fin8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (busy8 || fin8 || out8 != 16'd0 || busy16 || fin16 || out16 != 32'd0) ok = 1'b0;
        end
        check("idle_outputs_zero", ok, 1);

        // table vectors, W8/D1
        for (int i = 0; i < 8; i++) begin
            do_op(1'b0, tab[i].a, tab[i].b, longint'(tab[i].p), $sformatf("tab%0d", i));
        end

        // W16/D4 corner: all ones
        do_op(1'b1, 16'hFFFF, 16'hFFFF, 64'hFFFE0001, "w16_ffff");

        // random operands against plain multiplication
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_op(1'b0, {8'd0, ra}, {8'd0, rb}, longint'(ra) * longint'(rb), $sformatf("rnd8_%0d", i));
        end
        for (int i = 0; i < 10; i++) begin
            wa = 16'($urandom);
            wb = 16'($urandom);
            do_op(1'b1, wa, wb, longint'(wa) * longint'(wb), $sformatf("rnd16_%0d", i));
        end

        // start pulses with new operands during busy are ignored
        @(negedge clk);
        s8 = 1'b1; a8 = 8'd200; b8 = 8'd255;
        @(posedge clk);
        #1;
        s8 = 1'b0;
        cyc = 0;
        while (!fin8 && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 2 || cyc == 5) begin
                s8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
            end else begin
                s8 = 1'b0;
            end
        end
        s8 = 1'b0;
        check("ignore_latency", cyc, lat_model(64'd200, 8, 1));
        check("ignore_out", out8, 51000);
        @(posedge clk);
        #1;
        check("ignore_no_new_op", busy8, 0);

        // start held high: back-to-back ops with no gap cycle
        @(negedge clk);
        s8 = 1'b1; a8 = 8'd200; b8 = 8'd255;
        @(posedge clk);
        #1;
        a8 = 8'd3; b8 = 8'd7;
        cyc = 0;
        while (!fin8 && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("held_first_latency", cyc, lat_model(64'd200, 8, 1));
        check("held_first_out", out8, 51000);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!fin8 && cyc < 64);
        s8 = 1'b0;
        check("held_period", cyc, lat_model(64'd3, 8, 1) + 1);
        check("held_second_out", out8, 21);

        // reset mid-CALC: immediate abort, no finish afterwards
        @(posedge clk);
        #1;
        @(negedge clk);
        s8 = 1'b1; a8 = 8'd200; b8 = 8'd255;
        @(posedge clk);
        #1;
        s8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy8, 0);
        check("abort_out", out8, 0);
        check("abort_finish", fin8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (fin8 || busy8 || out8 != 16'd0) ok = 1'b0;
        end
        check("abort_no_finish", ok, 1);

        // recovery after reset
        do_op(1'b0, 16'd13, 16'd11, 143, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
